// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I core with req/ready instruction and data buses; halts on ecall/ebreak/illegal/bus fault.
// Optional macro PERF_COUNTERS_EN adds the cycle_cnt/instret_cnt outputs and their counters.
//
// state    | meaning
// S_FETCH  | imem_req high, wait for imem_ready, latch IR
// S_DECODE | read rs1/rs2 into A/B, latch immediate, trap illegal/system
// S_EXEC   | ALU op, branch/jump resolve, load/store address + alignment check
// S_MEM    | dmem_req high until dmem_ready; loads capture extended data
// S_WB     | write rd, advance PC (jumps already updated it)
// S_HALT   | absorbing stop state, no requests
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        halted,
    output logic        bus_err
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    localparam logic [31:0] WD_LOAD = (MAX_WAIT > 0) ? 32'(MAX_WAIT - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic [31:0] wdog_q, wdog_d;
    logic        bus_err_q, bus_err_d;

    logic [31:0] rf_q [32];
    logic        rf_we;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        legal;

    assign opcode  = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign f7      = ir_q[31:25];
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    always_comb begin
        imm   = 32'd0;
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm   = {ir_q[31:12], 12'd0};
                legal = 1'b1;
            end
            OP_JAL: begin
                imm   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
                legal = 1'b1;
            end
            OP_JALR: begin
                imm   = {{20{ir_q[31]}}, ir_q[31:20]};
                legal = (f3 == 3'd0);
            end
            OP_BR: begin
                imm   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OP_LOAD: begin
                imm   = {{20{ir_q[31]}}, ir_q[31:20]};
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            end
            OP_STORE: begin
                imm   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                legal = (f3 <= 3'd2);
            end
            OP_IMM: begin
                imm = {{20{ir_q[31]}}, ir_q[31:20]};
                if (f3 == 3'd1)      legal = (f7 == 7'd0);
                else if (f3 == 3'd5) legal = (f7 == 7'd0) || (f7 == 7'h20);
                else                 legal = 1'b1;
            end
            OP_REG:   legal = (f7 == 7'd0) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            OP_FENCE: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    logic [31:0] alu_b, alu_res, addr_sum, lane, load_val, st_data;
    logic [4:0]  shamt;
    logic [3:0]  st_be;
    logic        taken, misaligned;

    assign alu_b    = (opcode == OP_REG) ? b_q : imm_q;
    assign shamt    = alu_b[4:0];
    assign addr_sum = a_q + imm_q;
    assign lane     = dmem_rdata >> {res_q[1:0], 3'b000};

    always_comb begin
        alu_res = 32'd0;
        case (f3)
            3'd0: alu_res = (opcode == OP_REG && ir_q[30]) ? a_q - alu_b : a_q + alu_b;
            3'd1: alu_res = a_q << shamt;
            3'd2: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
            3'd3: alu_res = {31'd0, a_q < alu_b};
            3'd4: alu_res = a_q ^ alu_b;
            3'd5: alu_res = ir_q[30] ? 32'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'd6: alu_res = a_q | alu_b;
            default: alu_res = a_q & alu_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'd0: taken = (a_q == b_q);
            3'd1: taken = (a_q != b_q);
            3'd4: taken = $signed(a_q) < $signed(b_q);
            3'd5: taken = $signed(a_q) >= $signed(b_q);
            3'd6: taken = a_q < b_q;
            3'd7: taken = a_q >= b_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        load_val   = dmem_rdata;
        st_be      = 4'b1111;
        st_data    = b_q;
        case (f3[1:0])
            2'd1: misaligned = addr_sum[0];
            2'd2: misaligned = (addr_sum[1:0] != 2'd0);
            default: misaligned = 1'b0;
        endcase
        case (f3)
            3'd0: load_val = {{24{lane[7]}}, lane[7:0]};
            3'd4: load_val = {24'd0, lane[7:0]};
            3'd1: load_val = {{16{lane[15]}}, lane[15:0]};
            3'd5: load_val = {16'd0, lane[15:0]};
            default: load_val = dmem_rdata;
        endcase
        if (f3[1:0] == 2'd0) begin
            st_be   = 4'b0001 << res_q[1:0];
            st_data = {4{b_q[7:0]}};
        end else if (f3[1:0] == 2'd1) begin
            st_be   = res_q[1] ? 4'b1100 : 4'b0011;
            st_data = {2{b_q[15:0]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        res_d      = res_q;
        bus_err_d  = bus_err_q;
        wdog_d     = WD_LOAD;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_be    = 4'd0;
        dmem_wdata = 32'd0;
        rf_we      = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Reset must drop the request combinationally, before the clock.
                imem_req = rst_n;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_HALT;
                end else begin
                    a_d     = rs1_val;
                    b_d     = rs2_val;
                    imm_d   = imm;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_BR: begin
                        pc_d    = taken ? pc_q + imm_q : pc_q + 32'd4;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_d    = pc_q + imm_q;
                        res_d   = pc_q + 32'd4;
                        state_d = S_WB;
                    end
                    OP_JALR: begin
                        pc_d    = addr_sum & ~32'd1;
                        res_d   = pc_q + 32'd4;
                        state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        if (misaligned) begin
                            state_d   = S_HALT;
                            bus_err_d = 1'b1;
                        end else begin
                            res_d   = addr_sum;
                            state_d = S_MEM;
                        end
                    end
                    OP_LUI: begin
                        res_d   = imm_q;
                        state_d = S_WB;
                    end
                    OP_AUIPC: begin
                        res_d   = pc_q + imm_q;
                        state_d = S_WB;
                    end
                    OP_IMM, OP_REG: begin
                        res_d   = alu_res;
                        state_d = S_WB;
                    end
                    default: begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                dmem_be  = dmem_we ? st_be : 4'b1111;
                if (dmem_we) dmem_wdata = st_data;
                if (dmem_ready) begin
                    if (dmem_we) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = load_val;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we = (rd != 5'd0);
                if (opcode != OP_JAL && opcode != OP_JALR) pc_d = pc_q + 32'd4;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        if (MAX_WAIT != 0 && ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))) begin
            if (wdog_q == 32'd0) begin
                state_d   = S_HALT;
                bus_err_d = 1'b1;
            end else begin
                wdog_d = wdog_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            imm_q     <= 32'd0;
            res_q     <= 32'd0;
            wdog_q    <= WD_LOAD;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
            wdog_q    <= wdog_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rd] <= res_q;
    end

    assign imem_addr = pc_q;
    assign dmem_addr = {res_q[31:2], 2'b00};
    assign halted    = (state_q == S_HALT);
    assign bus_err   = bus_err_q;

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic             retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: small programs served by a bus model with configurable wait states.
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic [3:0]  dmem_be;
    logic        halted, bus_err;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_cpu #(.RESET_PC(32'h0), .MAX_WAIT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .halted(halted), .bus_err(bus_err)
`ifdef PERF_COUNTERS_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    int n_checks = 0, n_fail = 0;
    int cyc;
    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    int imem_delay = 0, dmem_delay = 0;
    bit dmem_hold = 1'b0;
    int icnt = 0, dcnt = 0;
    int nfetch = 0, nst = 0, dreq_cnt = 0, addr_viol = 0;
    logic [31:0] f_addr [32];
    int          f_cyc [32];
    logic [31:0] st_addr [8], st_wdata [8];
    logic [3:0]  st_be [8];
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

    // Bus model: ready decided on the falling edge, consumed at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ready = 1'b0; dmem_ready = 1'b0; icnt = 0; dcnt = 0; pend = 1'b0;
        end else begin
            imem_ready = 1'b0;
            if (imem_req) begin
                if (pend && imem_addr !== pend_addr) addr_viol++;
                imem_rdata = imem[imem_addr[5:2]];
                if (icnt >= imem_delay) begin
                    imem_ready = 1'b1; icnt = 0; pend = 1'b0;
                    if (nfetch < 32) begin f_addr[nfetch] = imem_addr; f_cyc[nfetch] = cyc; end
                    nfetch++;
                end else begin
                    icnt++; pend = 1'b1; pend_addr = imem_addr;
                end
            end else begin
                icnt = 0; pend = 1'b0;
            end
            dmem_ready = 1'b0;
            if (dmem_req) begin
                dreq_cnt++;
                dmem_rdata = dmem[dmem_addr[5:2]];
                if (!dmem_hold && dcnt >= dmem_delay) begin
                    dmem_ready = 1'b1; dcnt = 0;
                    if (dmem_we && nst < 8) begin
                        st_addr[nst] = dmem_addr; st_wdata[nst] = dmem_wdata; st_be[nst] = dmem_be;
                        nst++;
                    end
                end else begin
                    dcnt++;
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    function automatic logic [31:0] i_t(input logic [31:0] im, input logic [31:0] r1, input logic [31:0] f3,
                                        input logic [31:0] rd, input logic [6:0] op);
        return {im[11:0], r1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] r_t(input logic [31:0] f7, input logic [31:0] r2, input logic [31:0] r1,
                                        input logic [31:0] f3, input logic [31:0] rd);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] s_t(input logic [31:0] im, input logic [31:0] r2, input logic [31:0] r1,
                                        input logic [31:0] f3);
        return {im[11:5], r2[4:0], r1[4:0], f3[2:0], im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input logic [31:0] im, input logic [31:0] r2, input logic [31:0] r1,
                                        input logic [31:0] f3);
        return {im[12], im[10:5], r2[4:0], r1[4:0], f3[2:0], im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input logic [31:0] im, input logic [31:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin imem[i] = 32'd0; dmem[i] = 32'd0; end
    endtask

    task automatic enter_reset(input int idly, input int ddly, input bit hold);
        rst_n = 1'b0;
        #1;
        imem_delay = idly; dmem_delay = ddly; dmem_hold = hold;
        nfetch = 0; nst = 0; dreq_cnt = 0; addr_viol = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        // addi x1,x0,5 ; add x2,x1,x1 ; sw x2,0x20(x0) ; ecall
        clear_prog();
        imem[0] = i_t(5, 0, 0, 1, OP_IMM);
        imem[1] = r_t(0, 1, 1, 0, 2);
        imem[2] = s_t(32'h20, 2, 0, 2);
        imem[3] = ECALL;
        #3;
        enter_reset(0, 0, 1'b0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_pc", imem_addr, 32'h0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
`ifdef PERF_COUNTERS_EN
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
`endif
        release_reset();
        run_halt("t1_halt", 100);
        check("t1_fetch0", f_addr[0], 32'h0);
        check("t1_fetch1", f_addr[1], 32'h4);
        check("t1_addi_lat", 32'(f_cyc[1] - f_cyc[0]), 32'd4);
        check("t1_x2_at_cycle8", 32'(f_cyc[2] - f_cyc[0]), 32'd8);
        check("t1_sw_lat", 32'(f_cyc[3] - f_cyc[2]), 32'd4);
        check("t1_nst", 32'(nst), 32'd1);
        check("t1_st_data", st_wdata[0], 32'd10);
        check("t1_st_addr", st_addr[0], 32'h20);
        check("t1_st_be", {28'd0, st_be[0]}, 32'hF);
        check("ecall_bus_err", {31'd0, bus_err}, 32'd0);
        check("ecall_pc_held", imem_addr, 32'd12);
        check("halt_no_ireq", {31'd0, imem_req}, 32'd0);

        // same program, three wait states per fetch
        enter_reset(3, 0, 1'b0);
        release_reset();
        run_halt("t2_halt", 200);
        check("t2_addi_lat", 32'(f_cyc[1] - f_cyc[0]), 32'd7);
        check("t2_add_lat", 32'(f_cyc[2] - f_cyc[1]), 32'd7);
        check("t2_fetch1", f_addr[1], 32'h4);
        check("t2_st_data", st_wdata[0], 32'd10);
        check("t2_addr_stable", 32'(addr_viol), 32'd0);

        // reset pulse while the second fetch is stalled
        enter_reset(2, 0, 1'b0);
        release_reset();
        begin
            int n = 0;
            while (!(imem_req && imem_addr == 32'h4) && n < 50) begin @(negedge clk); n++; end
            check("t3_reached_stall", imem_addr, 32'h4);
        end
        rst_n = 1'b0;
        #1;
        check("t3_req_drop", {31'd0, imem_req}, 32'd0);
        check("t3_pc_reset", imem_addr, 32'h0);
        nfetch = 0; nst = 0; imem_delay = 0;
        release_reset();
        run_halt("t3_halt", 100);
        check("t3_restart_fetch", f_addr[0], 32'h0);
        check("t3_st_data", st_wdata[0], 32'd10);

        // byte/half stores and loads
        clear_prog();
        dmem[0] = 32'h0000_8000;
        imem[0] = i_t(32'hAB, 0, 0, 3, OP_IMM);
        imem[1] = s_t(1, 3, 0, 0);
        imem[2] = i_t(1, 0, 0, 4, OP_LOAD);
        imem[3] = i_t(1, 0, 4, 5, OP_LOAD);
        imem[4] = i_t(0, 0, 1, 6, OP_LOAD);
        imem[5] = s_t(32'h10, 4, 0, 2);
        imem[6] = s_t(32'h14, 5, 0, 2);
        imem[7] = s_t(32'h18, 6, 0, 2);
        imem[8] = ECALL;
        enter_reset(0, 0, 1'b0);
        release_reset();
        run_halt("t4_halt", 200);
        check("t4_nst", 32'(nst), 32'd4);
        check("sb_be", {28'd0, st_be[0]}, 32'b0010);
        check("sb_wdata", st_wdata[0], 32'hABAB_ABAB);
        check("sb_addr", st_addr[0], 32'h0);
        check("lb_val", st_wdata[1], 32'hFFFF_FF80);
        check("lbu_val", st_wdata[2], 32'h0000_0080);
        check("lh_val", st_wdata[3], 32'hFFFF_8000);
        check("sb_lat", 32'(f_cyc[2] - f_cyc[1]), 32'd4);
        check("lb_lat", 32'(f_cyc[3] - f_cyc[2]), 32'd5);

        // branches with x1=0xFFFFFFFF, x2=1
        clear_prog();
        imem[0] = i_t(-1, 0, 0, 1, OP_IMM);
        imem[1] = i_t(1, 0, 0, 2, OP_IMM);
        imem[2] = b_t(8, 2, 1, 6);
        imem[3] = b_t(8, 2, 1, 4);
        imem[4] = s_t(32'h20, 1, 0, 2);
        imem[5] = b_t(8, 2, 1, 7);
        imem[6] = ECALL;
        imem[7] = b_t(8, 1, 1, 1);
        imem[8] = b_t(-8, 2, 2, 0);
        enter_reset(0, 0, 1'b0);
        release_reset();
        run_halt("t5_halt", 200);
        check("bltu_not_taken", f_addr[3], 32'd12);
        check("blt_taken", f_addr[4], 32'd20);
        check("bgeu_taken", f_addr[5], 32'd28);
        check("bne_not_taken", f_addr[6], 32'd32);
        check("beq_back", f_addr[7], 32'd24);
        check("br_skip_store", 32'(nst), 32'd0);
        check("br_nt_lat", 32'(f_cyc[3] - f_cyc[2]), 32'd3);
        check("br_t_lat", 32'(f_cyc[4] - f_cyc[3]), 32'd3);

        // jal over a store, then jalr x5,7(x0) lands at 6
        clear_prog();
        imem[0] = j_t(12, 0);
        imem[1] = s_t(32'h20, 5, 0, 2);
        imem[2] = ECALL;
        imem[3] = i_t(7, 0, 0, 5, OP_JALR);
        enter_reset(0, 0, 1'b0);
        release_reset();
        run_halt("t6_halt", 200);
        check("jal_target", f_addr[1], 32'd12);
        check("jalr_target", f_addr[2], 32'd6);
        check("jalr_link", st_wdata[0], 32'd16);
        check("jal_lat", 32'(f_cyc[1] - f_cyc[0]), 32'd4);
        check("jalr_lat", 32'(f_cyc[2] - f_cyc[1]), 32'd4);
        check("t6_pc_held", imem_addr, 32'd10);

        // data watchdog: lw with dmem_ready never asserted
        clear_prog();
        imem[0] = i_t(0, 0, 2, 1, OP_LOAD);
        enter_reset(0, 0, 1'b1);
        release_reset();
        run_halt("wd_halt", 100);
        check("wd_bus_err", {31'd0, bus_err}, 32'd1);
        check("wd_req_cycles", 32'(dreq_cnt), 32'd4);
        check("wd_req_dropped", {31'd0, dmem_req}, 32'd0);

        // misaligned lw at 0x2
        clear_prog();
        imem[0] = i_t(2, 0, 0, 1, OP_IMM);
        imem[1] = i_t(0, 1, 2, 2, OP_LOAD);
        enter_reset(0, 0, 1'b0);
        release_reset();
        run_halt("mis_halt", 100);
        check("mis_bus_err", {31'd0, bus_err}, 32'd1);
        check("mis_no_dreq", 32'(dreq_cnt), 32'd0);
        check("mis_pc", imem_addr, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
